tcdm_wide_splitter: RTL and testbench

Downstream partner of the wide-port grouping stage: takes one wide TCDM request (SIZE lanes of DATA_WIDTH bits sharing one address, wen and req) and issues it as SIZE independent narrow TCDM requests to consecutive banks. Each narrow port grants on its own. The block tracks per-lane grants and responses and returns one wide grant and one wide response. One wide transaction is in flight at a time.

---
 rtl/tcdm_split_pkg.sv | 14 +
 rtl/tcdm_split_lane.sv | 67 ++++++
 rtl/tcdm_wide_splitter.sv | 101 ++++++++++
 tb/tb_tcdm_wide_splitter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_split_pkg.sv
// Shared types for the wide-to-narrow TCDM splitter: FSM state encoding and lane mask.
package tcdm_split_pkg;

  localparam int unsigned SPLIT_SIZE = 4;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [SPLIT_SIZE-1:0] lane_mask_t;

endpackage

// File: rtl/tcdm_split_lane.sv
// One narrow lane of the splitter: request gating, address offset, grant/response tracking.
// TCDM_SPLIT_SKIP_EMPTY_LANE_EN: lanes with all-zero byte enables are never requested.
module tcdm_split_lane
  import tcdm_split_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned LANE       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] add,
  input  logic [BE_WIDTH-1:0]   be,
  input  logic                  issue_en,
  input  logic                  wide_gnt,
  input  logic                  rsp_clr,
  input  logic                  gnt,
  input  logic                  r_valid,
  input  logic [DATA_WIDTH-1:0] r_rdata,
  output logic                  tcdm_req_c,
  output logic [ADDR_WIDTH-1:0] tcdm_add_c,
  output logic                  gnt_ok_c,
  output logic                  rsp_ok_c,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic gnt_q;
  logic rsp_q;
  logic empty;

`ifdef TCDM_SPLIT_SKIP_EMPTY_LANE_EN
  assign empty = (be == '0);
`else
  logic unused_be;
  assign unused_be = ^be;
  assign empty     = 1'b0;
`endif

  assign tcdm_req_c = req & rst_n & issue_en & ~gnt_q & ~empty;
  assign tcdm_add_c = add + ADDR_WIDTH'(LANE * BE_WIDTH);
  assign gnt_ok_c   = gnt_q | gnt | empty;
  assign rsp_ok_c   = rsp_q | r_valid;

  // Response capture runs in every state so lanes answering before the wide grant are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= 1'b0;
      rsp_q <= 1'b0;
      rdata <= '0;
    end else begin
      if (wide_gnt) begin
        gnt_q <= 1'b0;
      end else if (tcdm_req_c && gnt) begin
        gnt_q <= 1'b1;
      end
      rsp_q <= (rsp_q & ~rsp_clr) | r_valid | (wide_gnt & empty);
      if (r_valid) begin
        rdata <= r_rdata;
      end else if (wide_gnt && empty) begin
        rdata <= '0;
      end
    end
  end

endmodule

// File: rtl/tcdm_wide_splitter.sv
// Splits one wide TCDM request into SIZE narrow requests to consecutive banks, one in flight.
// TCDM_SPLIT_SKIP_EMPTY_LANE_EN: skip lanes whose byte enables are all zero.
module tcdm_wide_splitter
  import tcdm_split_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned SIZE       = SPLIT_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       data_req_i,
  input  logic [ADDR_WIDTH-1:0]      data_add_i,
  input  logic                       data_wen_i,
  input  logic [SIZE*DATA_WIDTH-1:0] data_wdata_i,
  input  logic [SIZE*BE_WIDTH-1:0]   data_be_i,
  output logic                       data_gnt_o,
  output logic                       data_r_valid_o,
  output logic [SIZE*DATA_WIDTH-1:0] data_r_rdata_o,
  output logic [SIZE-1:0]            tcdm_req_o,
  output logic [ADDR_WIDTH-1:0]      tcdm_add_o     [SIZE],
  output logic [SIZE-1:0]            tcdm_wen_o,
  output logic [DATA_WIDTH-1:0]      tcdm_wdata_o   [SIZE],
  output logic [BE_WIDTH-1:0]        tcdm_be_o      [SIZE],
  input  logic [SIZE-1:0]            tcdm_gnt_i,
  input  logic [SIZE-1:0]            tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0]      tcdm_r_rdata_i [SIZE]
);

  state_t          state_q;
  state_t          state_d;
  logic            issue_en;
  logic            wide_gnt;
  logic            rsp_clr;
  logic [SIZE-1:0] gnt_ok;
  logic [SIZE-1:0] rsp_ok;

  assign issue_en   = (state_q == ISSUE) || (state_q == DONE);
  assign wide_gnt   = rst_n & data_req_i & issue_en & (&gnt_ok);
  assign rsp_clr    = (state_q == DONE);
  assign data_gnt_o = wide_gnt;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    tcdm_split_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .BE_WIDTH   (BE_WIDTH),
      .LANE       (i)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (data_req_i),
      .add        (data_add_i),
      .be         (data_be_i[i*BE_WIDTH +: BE_WIDTH]),
      .issue_en   (issue_en),
      .wide_gnt   (wide_gnt),
      .rsp_clr    (rsp_clr),
      .gnt        (tcdm_gnt_i[i]),
      .r_valid    (tcdm_r_valid_i[i]),
      .r_rdata    (tcdm_r_rdata_i[i]),
      .tcdm_req_c (tcdm_req_o[i]),
      .tcdm_add_c (tcdm_add_o[i]),
      .gnt_ok_c   (gnt_ok[i]),
      .rsp_ok_c   (rsp_ok[i]),
      .rdata      (data_r_rdata_o[i*DATA_WIDTH +: DATA_WIDTH])
    );

    assign tcdm_wen_o[i]   = data_wen_i;
    assign tcdm_wdata_o[i] = data_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    assign tcdm_be_o[i]    = data_be_i[i*BE_WIDTH +: BE_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ISSUE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; the wide response is a pure decode of DONE.
  always_comb begin
    state_d        = state_q;
    data_r_valid_o = 1'b0;
    case (state_q)
      ISSUE: begin
        if (wide_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (&rsp_ok) state_d = DONE;
      end
      DONE: begin
        data_r_valid_o = 1'b1;
        state_d        = wide_gnt ? WAIT : ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

endmodule

// File: tb/tb_tcdm_wide_splitter.sv
// Directed bench for tcdm_wide_splitter: hand-driven banks, scoreboard of expected wide rdata.
module tb_tcdm_wide_splitter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned N  = 4;

  logic            clk;
  logic            rst_n;
  logic            data_req;
  logic [AW-1:0]   data_add;
  logic            data_wen;
  logic [N*DW-1:0] data_wdata;
  logic [N*BW-1:0] data_be;
  logic            data_gnt;
  logic            data_r_valid;
  logic [N*DW-1:0] data_r_rdata;
  logic [N-1:0]    tcdm_req;
  logic [AW-1:0]   tcdm_add   [N];
  logic [N-1:0]    tcdm_wen;
  logic [DW-1:0]   tcdm_wdata [N];
  logic [BW-1:0]   tcdm_be    [N];
  logic [N-1:0]    tcdm_gnt;
  logic [N-1:0]    tcdm_r_valid;
  logic [DW-1:0]   tcdm_r_rdata [N];

  int total = 0;
  int bad   = 0;
  logic [N*DW-1:0] sb [$];

  tcdm_wide_splitter #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BE_WIDTH (BW), .SIZE (N)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_req_i     (data_req),
    .data_add_i     (data_add),
    .data_wen_i     (data_wen),
    .data_wdata_i   (data_wdata),
    .data_be_i      (data_be),
    .data_gnt_o     (data_gnt),
    .data_r_valid_o (data_r_valid),
    .data_r_rdata_o (data_r_rdata),
    .tcdm_req_o     (tcdm_req),
    .tcdm_add_o     (tcdm_add),
    .tcdm_wen_o     (tcdm_wen),
    .tcdm_wdata_o   (tcdm_wdata),
    .tcdm_be_o      (tcdm_be),
    .tcdm_gnt_i     (tcdm_gnt),
    .tcdm_r_valid_i (tcdm_r_valid),
    .tcdm_r_rdata_i (tcdm_r_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wide response check: pops the scoreboard only when a response is expected.
  task automatic chk_rsp(input string tag, input logic exp_valid);
    logic [N*DW-1:0] exp;
    chk({tag, "_rvalid"}, (N*DW)'(data_r_valid), (N*DW)'(exp_valid));
    if (exp_valid) begin
      chk({tag, "_sb_nonempty"}, (N*DW)'(sb.size() != 0), (N*DW)'(1'b1));
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk({tag, "_rdata"}, data_r_rdata, exp);
      end
    end
  endtask

  task automatic set_rd(input logic [DW-1:0] base);
    for (int i = 0; i < N; i++) tcdm_r_rdata[i] = base + DW'(i);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; data_req = 1'b1; data_add = '0; data_wen = 1'b1;
    data_wdata = '0; data_be = '1; tcdm_gnt = '0; tcdm_r_valid = '0;
    set_rd(32'h0);
    step(); settle();
    chk("rst_req", (N*DW)'(tcdm_req), '0);
    chk("rst_gnt", (N*DW)'(data_gnt), '0);
    chk("rst_rvalid", (N*DW)'(data_r_valid), '0);
    chk("rst_rdata", data_r_rdata, '0);
    data_req = 1'b0;
    step(); rst_n = 1'b1;

    // Plain load at 0x1000
    step(); data_req = 1'b1; data_add = 32'h1000; data_wen = 1'b1; tcdm_gnt = '1; settle();
    for (int i = 0; i < N; i++) chk("ld_add", (N*DW)'(tcdm_add[i]), (N*DW)'(32'h1000 + 4 * i));
    chk("ld_req", (N*DW)'(tcdm_req), (N*DW)'(4'hF));
    chk("ld_gnt", (N*DW)'(data_gnt), (N*DW)'(1'b1));
    chk_rsp("ld_c0", 1'b0);
    sb.push_back({32'hA3, 32'hA2, 32'hA1, 32'hA0});
    step(); data_req = 1'b0; tcdm_gnt = '0; tcdm_r_valid = '1; set_rd(32'hA0); settle();
    chk("ld_c1_req", (N*DW)'(tcdm_req), '0);
    chk("ld_c1_gnt", (N*DW)'(data_gnt), '0);
    chk_rsp("ld_c1", 1'b0);
    step(); tcdm_r_valid = '0; set_rd(32'hEE0); settle();
    chk_rsp("ld_c2", 1'b1);
    step(); settle();
    chk_rsp("ld_c3", 1'b0);

    // Staggered grants: lane 2 granted at cycle 3
    step(); data_req = 1'b1; data_add = 32'h2000; tcdm_gnt = 4'b1011; settle();
    chk("st_c0_req", (N*DW)'(tcdm_req), (N*DW)'(4'hF));
    chk("st_c0_gnt", (N*DW)'(data_gnt), '0);
    step(); tcdm_gnt = '0; tcdm_r_valid = 4'b1011; set_rd(32'hB0); tcdm_r_rdata[2] = 32'hDEAD; settle();
    chk("st_c1_req", (N*DW)'(tcdm_req), (N*DW)'(4'b0100));
    chk("st_c1_gnt", (N*DW)'(data_gnt), '0);
    step(); tcdm_r_valid = '0; settle();
    chk("st_c2_req", (N*DW)'(tcdm_req), (N*DW)'(4'b0100));
    chk("st_c2_gnt", (N*DW)'(data_gnt), '0);
    step(); tcdm_gnt = 4'b0100; settle();
    chk("st_c3_gnt", (N*DW)'(data_gnt), (N*DW)'(1'b1));
    sb.push_back({32'hB3, 32'hB2, 32'hB1, 32'hB0});
    step(); data_req = 1'b0; tcdm_gnt = '0; tcdm_r_valid = 4'b0100; tcdm_r_rdata[2] = 32'hB2; settle();
    chk_rsp("st_c4", 1'b0);
    step(); tcdm_r_valid = '0; settle();
    chk_rsp("st_c5", 1'b1);

    // Back-to-back stores, second grant in DONE
    step(); data_req = 1'b1; data_add = 32'h0; data_wen = 1'b0;
    data_wdata = {32'hC3, 32'hC2, 32'hC1, 32'hC0}; tcdm_gnt = '1; settle();
    chk("bb_c0_gnt", (N*DW)'(data_gnt), (N*DW)'(1'b1));
    chk("bb_wen", (N*DW)'(tcdm_wen), '0);
    chk("bb_wdata1", (N*DW)'(tcdm_wdata[1]), (N*DW)'(32'hC1));
    sb.push_back({32'h13, 32'h12, 32'h11, 32'h10});
    step(); data_add = 32'h10; data_wdata = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    tcdm_r_valid = '1; set_rd(32'h10); settle();
    chk("bb_c1_req", (N*DW)'(tcdm_req), '0);
    chk("bb_c1_gnt", (N*DW)'(data_gnt), '0);
    step(); tcdm_r_valid = '0; settle();
    chk("bb_c2_gnt", (N*DW)'(data_gnt), (N*DW)'(1'b1));
    chk("bb_c2_add0", (N*DW)'(tcdm_add[0]), (N*DW)'(32'h10));
    chk_rsp("bb_c2", 1'b1);
    sb.push_back({32'h23, 32'h22, 32'h21, 32'h20});
    step(); data_req = 1'b0; tcdm_gnt = '0; tcdm_r_valid = '1; set_rd(32'h20); settle();
    chk_rsp("bb_c3", 1'b0);
    step(); tcdm_r_valid = '0; settle();
    chk_rsp("bb_c4", 1'b1);
    step(); settle();
    chk_rsp("bb_c5", 1'b0);

    // Address wrap, no grant given
    step(); data_req = 1'b1; data_add = 32'hFFFF_FFF8; data_wen = 1'b1; settle();
    chk("wr_add0", (N*DW)'(tcdm_add[0]), (N*DW)'(32'hFFFF_FFF8));
    chk("wr_add1", (N*DW)'(tcdm_add[1]), (N*DW)'(32'hFFFF_FFFC));
    chk("wr_add2", (N*DW)'(tcdm_add[2]), (N*DW)'(32'h0));
    chk("wr_add3", (N*DW)'(tcdm_add[3]), (N*DW)'(32'h4));
    step(); data_req = 1'b0; settle();

    // Reset while waiting for responses
    step(); data_req = 1'b1; data_add = 32'h3000; tcdm_gnt = '1; settle();
    chk("rs_c0_gnt", (N*DW)'(data_gnt), (N*DW)'(1'b1));
    step(); data_req = 1'b0; tcdm_gnt = '0; rst_n = 1'b0; tcdm_r_valid = '1; set_rd(32'h77); settle();
    chk_rsp("rs_c1", 1'b0);
    step(); settle();
    chk_rsp("rs_c2", 1'b0);
    step(); rst_n = 1'b1; tcdm_r_valid = '0; settle();
    chk_rsp("rs_c3", 1'b0);
    chk("rs_c3_rdata", data_r_rdata, '0);
    chk("rs_c3_req", (N*DW)'(tcdm_req), '0);
    step(); settle();
    chk_rsp("rs_c4", 1'b0);
    step(); data_req = 1'b1; data_add = 32'h4000; settle();
    chk("rs_issue_req", (N*DW)'(tcdm_req), (N*DW)'(4'hF));
    step(); data_req = 1'b0; settle();

    // Byte enables with lanes 1 and 3 empty
    step(); data_req = 1'b1; data_add = 32'h5000; data_be = 16'h0F0F; tcdm_gnt = '1; settle();
`ifdef TCDM_SPLIT_SKIP_EMPTY_LANE_EN
    chk("be_req", (N*DW)'(tcdm_req), (N*DW)'(4'b0101));
    sb.push_back({32'h0, 32'hE2, 32'h0, 32'hE0});
`else
    chk("be_req", (N*DW)'(tcdm_req), (N*DW)'(4'b1111));
    sb.push_back({32'hE3, 32'hE2, 32'hE1, 32'hE0});
`endif
    chk("be_gnt", (N*DW)'(data_gnt), (N*DW)'(1'b1));
    step(); data_req = 1'b0; tcdm_gnt = '0; set_rd(32'hE0);
`ifdef TCDM_SPLIT_SKIP_EMPTY_LANE_EN
    tcdm_r_valid = 4'b0101;
`else
    tcdm_r_valid = 4'b1111;
`endif
    settle();
    chk_rsp("be_c1", 1'b0);
    step(); tcdm_r_valid = '0; settle();
    chk_rsp("be_c2", 1'b1);

    chk("sb_drained", (N*DW)'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
